// File: rtl/parking_gate_ctrl_pkg.sv
// Shared widths, class encoding and the time-of-day uni reservation schedule.
package parking_pkg;

    localparam int unsigned CNT_W_DEF = 10;
    localparam int unsigned HOUR_W    = 5;
    localparam int unsigned MIN_W     = 6;

    typedef enum logic {
        CLS_GEN = 1'b0,
        CLS_UNI = 1'b1
    } cls_e;

    // Uni reservation for hour h: flat peak, stepped ramp down (floored at off), flat off-peak.
    function automatic int unsigned uni_cap_at(
        input int unsigned h,
        input int unsigned cap_peak,
        input int unsigned cap_off,
        input int unsigned peak_start,
        input int unsigned peak_end,
        input int unsigned ramp_end,
        input int unsigned ramp_step
    );
        int unsigned dec;
        if (h >= peak_start && h < peak_end) begin
            return cap_peak;
        end
        if (h >= peak_end && h < ramp_end) begin
            dec = (h - peak_end + 1) * ramp_step;
            if (cap_peak > cap_off && dec < cap_peak - cap_off) begin
                return cap_peak - dec;
            end
            return cap_off;
        end
        return cap_off;
    endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Gate request/acknowledge bundle between barrier logic (master) and controller (slave).
interface parking_gate_ctrl_if;

    logic ent_req;
    logic ent_uni;
    logic exit_req;
    logic exit_uni;
    logic ent_ack;
    logic ent_grant;
    logic exit_ack;
    logic exit_err;

    modport master (
        output ent_req, ent_uni, exit_req, exit_uni,
        input  ent_ack, ent_grant, exit_ack, exit_err
    );

    modport slave (
        input  ent_req, ent_uni, exit_req, exit_uni,
        output ent_ack, ent_grant, exit_ack, exit_err
    );

endinterface

// File: rtl/parking_gate_ctrl_clock.sv
// Minute/hour time-of-day counter; a load takes priority over a minute tick.
module parking_clock
    import parking_pkg::*;
#(
    parameter int unsigned INIT_HOUR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_min,
    input  logic              time_load,
    input  logic [HOUR_W-1:0] hour_in,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  minute
);

    // Load clears the minute and sanitises out-of-range hours to 0; tick carries 59->0 into hour 23->0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour   <= HOUR_W'(INIT_HOUR);
            minute <= '0;
        end else if (time_load) begin
            hour   <= (hour_in > HOUR_W'(23)) ? '0 : hour_in;
            minute <= '0;
        end else if (tick_min) begin
            if (minute == MIN_W'(59)) begin
                minute <= '0;
                hour   <= (hour == HOUR_W'(23)) ? '0 : hour + HOUR_W'(1);
            end else begin
                minute <= minute + MIN_W'(1);
            end
        end
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking admission controller: uni/general occupancy against an hourly capacity schedule.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned TOTAL_CAP    = 700,
    parameter int unsigned UNI_CAP_PEAK = 500,
    parameter int unsigned UNI_CAP_OFF  = 200,
    parameter int unsigned PEAK_START   = 8,
    parameter int unsigned PEAK_END     = 13,
    parameter int unsigned RAMP_END     = 16,
    parameter int unsigned RAMP_STEP    = 50,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned INIT_HOUR    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_min,
    input  logic                 time_load,
    input  logic [HOUR_W-1:0]    hour_in,
    parking_gate_ctrl_if.slave   gate,
    output logic [HOUR_W-1:0]    hour,
    output logic [MIN_W-1:0]     minute,
    output logic [CNT_W-1:0]     uni_parked,
    output logic [CNT_W-1:0]     gen_parked,
    output logic [CNT_W-1:0]     uni_free,
    output logic [CNT_W-1:0]     gen_free,
    output logic                 uni_avail,
    output logic                 gen_avail
);

    if (TOTAL_CAP >= (64'd1 << CNT_W)) begin : g_total_cap_chk
        $error("TOTAL_CAP must fit in CNT_W bits");
    end
    if (UNI_CAP_PEAK > TOTAL_CAP || UNI_CAP_OFF > TOTAL_CAP) begin : g_uni_cap_chk
        $error("uni reservation exceeds TOTAL_CAP");
    end

    logic [CNT_W-1:0] uni_cnt;
    logic [CNT_W-1:0] gen_cnt;
    logic [CNT_W-1:0] uni_cap;
    logic [CNT_W-1:0] gen_cap;
    logic [CNT_W-1:0] uni_post;
    logic [CNT_W-1:0] gen_post;
    logic [CNT_W-1:0] uni_next;
    logic [CNT_W-1:0] gen_next;
    logic             exit_ok;
    logic             err_next;
    logic             grant_next;
    cls_e             ent_cls;
    cls_e             exit_cls;

    parking_clock #(
        .INIT_HOUR (INIT_HOUR)
    ) u_clock (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_min  (tick_min),
        .time_load (time_load),
        .hour_in   (hour_in),
        .hour      (hour),
        .minute    (minute)
    );

    assign ent_cls  = cls_e'(gate.ent_uni);
    assign exit_cls = cls_e'(gate.exit_uni);

    assign uni_cap = CNT_W'(uni_cap_at(32'(hour), UNI_CAP_PEAK, UNI_CAP_OFF,
                                       PEAK_START, PEAK_END, RAMP_END, RAMP_STEP));
    assign gen_cap = CNT_W'(TOTAL_CAP) - uni_cap;

    // Free space saturates at 0 when the schedule shrinks capacity below occupancy.
    assign uni_free   = (uni_cap > uni_cnt) ? uni_cap - uni_cnt : '0;
    assign gen_free   = (gen_cap > gen_cnt) ? gen_cap - gen_cnt : '0;
    assign uni_avail  = |uni_free;
    assign gen_avail  = |gen_free;
    assign uni_parked = uni_cnt;
    assign gen_parked = gen_cnt;

    // Exit is applied first, then the entry is judged against the post-exit occupancy.
    always_comb begin
        uni_post   = uni_cnt;
        gen_post   = gen_cnt;
        exit_ok    = 1'b0;
        err_next   = 1'b0;
        if (gate.exit_req) begin
            if (exit_cls == CLS_UNI) begin
                if (uni_cnt == '0) begin
                    err_next = 1'b1;
                end else begin
                    uni_post = uni_cnt - CNT_W'(1);
                    exit_ok  = 1'b1;
                end
            end else begin
                if (gen_cnt == '0) begin
                    err_next = 1'b1;
                end else begin
                    gen_post = gen_cnt - CNT_W'(1);
                    exit_ok  = 1'b1;
                end
            end
        end

        uni_next   = uni_post;
        gen_next   = gen_post;
        grant_next = 1'b0;
        if (gate.ent_req) begin
            // A same-class swap always admits: the entering car takes the space just vacated.
            if (exit_ok && exit_cls == ent_cls) begin
                grant_next = 1'b1;
            end else if (ent_cls == CLS_UNI) begin
                grant_next = (uni_cap > uni_post);
            end else begin
                grant_next = (gen_cap > gen_post);
            end
            if (grant_next) begin
                if (ent_cls == CLS_UNI) begin
                    uni_next = uni_post + CNT_W'(1);
                end else begin
                    gen_next = gen_post + CNT_W'(1);
                end
            end
        end
    end

    // Occupancy registers and single-cycle acknowledge/status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uni_cnt        <= '0;
            gen_cnt        <= '0;
            gate.ent_ack   <= 1'b0;
            gate.ent_grant <= 1'b0;
            gate.exit_ack  <= 1'b0;
            gate.exit_err  <= 1'b0;
        end else begin
            uni_cnt        <= uni_next;
            gen_cnt        <= gen_next;
            gate.ent_ack   <= gate.ent_req;
            gate.ent_grant <= grant_next;
            gate.exit_ack  <= gate.exit_req;
            gate.exit_err  <= err_next;
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: directed scenarios plus randomized traffic.
module tb_parking_gate_ctrl;

    localparam int TOTAL = 700;

    typedef struct {
        int due;
        int val;
    } resp_t;

    typedef struct {
        int due;
        int up;
        int gp;
        int hr;
        int mn;
    } state_t;

    logic       clk;
    logic       rst_n;
    logic       tick_min;
    logic       time_load;
    logic [4:0] hour_in;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [9:0] uni_parked;
    logic [9:0] gen_parked;
    logic [9:0] uni_free;
    logic [9:0] gen_free;
    logic       uni_avail;
    logic       gen_avail;

    parking_gate_ctrl_if gate ();

    parking_gate_ctrl #(
        .TOTAL_CAP    (700),
        .UNI_CAP_PEAK (500),
        .UNI_CAP_OFF  (200),
        .PEAK_START   (8),
        .PEAK_END     (13),
        .RAMP_END     (16),
        .RAMP_STEP    (50),
        .CNT_W        (10),
        .INIT_HOUR    (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_min   (tick_min),
        .time_load  (time_load),
        .hour_in    (hour_in),
        .gate       (gate),
        .hour       (hour),
        .minute     (minute),
        .uni_parked (uni_parked),
        .gen_parked (gen_parked),
        .uni_free   (uni_free),
        .gen_free   (gen_free),
        .uni_avail  (uni_avail),
        .gen_avail  (gen_avail)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 0;

    resp_t  ent_q[$];
    resp_t  exit_q[$];
    state_t st_q[$];

    // Reference model state: occupancy and time of day as plain integers.
    int m_uni, m_gen, m_hour, m_min;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2ms;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Uni reservation schedule written out hour by hour.
    function automatic int ucap(int h);
        case (h)
            8, 9, 10, 11, 12: return 500;
            13:               return 450;
            14:               return 400;
            15:               return 350;
            default:          return 200;
        endcase
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and advance the model to predict the following edge.
    task automatic drive(bit ent, bit eu, bit ex, bit xu, bit tick, bit load, int hr);
        int  cu;
        bit  ex_ok;
        bit  err;
        bit  grant;
        resp_t  r;
        state_t s;
        @(posedge clk);
        #1;
        gate.ent_req  = ent;
        gate.ent_uni  = eu;
        gate.exit_req = ex;
        gate.exit_uni = xu;
        tick_min      = tick;
        time_load     = load;
        hour_in       = 5'(hr);

        cu    = ucap(m_hour);
        ex_ok = 0;
        if (ex) begin
            err = xu ? (m_uni == 0) : (m_gen == 0);
            if (!err) begin
                ex_ok = 1;
                if (xu) m_uni--; else m_gen--;
            end
            r.due = cyc + 1;
            r.val = int'(err);
            exit_q.push_back(r);
        end
        if (ent) begin
            if (ex_ok && xu == eu) grant = 1;
            else if (eu)           grant = (cu > m_uni);
            else                   grant = ((TOTAL - cu) > m_gen);
            if (grant) begin
                if (eu) m_uni++; else m_gen++;
            end
            r.due = cyc + 1;
            r.val = int'(grant);
            ent_q.push_back(r);
        end
        if (load) begin
            m_hour = (hr > 23) ? 0 : hr;
            m_min  = 0;
        end else if (tick) begin
            if (m_min == 59) begin
                m_min  = 0;
                m_hour = (m_hour + 1) % 24;
            end else begin
                m_min++;
            end
        end
        s.due = cyc + 1;
        s.up  = m_uni;
        s.gp  = m_gen;
        s.hr  = m_hour;
        s.mn  = m_min;
        st_q.push_back(s);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        idle();
        @(negedge clk);
    endtask

    // Monitor: pops expected responses when acks appear and checks the status outputs each cycle.
    resp_t  mr;
    state_t ms;
    int     m_uc, m_uf, m_gf;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (gate.ent_ack) begin
                if (ent_q.size() == 0) begin
                    chk("ent_ack_spurious", int'(gate.ent_ack), 0);
                end else begin
                    mr = ent_q.pop_front();
                    chk("ent_ack_cycle", cyc, mr.due);
                    chk("ent_grant", int'(gate.ent_grant), mr.val);
                end
            end else if (ent_q.size() != 0 && ent_q[0].due <= cyc) begin
                mr = ent_q.pop_front();
                chk("ent_ack_missing", int'(gate.ent_ack), 1);
            end

            if (gate.exit_ack) begin
                if (exit_q.size() == 0) begin
                    chk("exit_ack_spurious", int'(gate.exit_ack), 0);
                end else begin
                    mr = exit_q.pop_front();
                    chk("exit_ack_cycle", cyc, mr.due);
                    chk("exit_err", int'(gate.exit_err), mr.val);
                end
            end else if (exit_q.size() != 0 && exit_q[0].due <= cyc) begin
                mr = exit_q.pop_front();
                chk("exit_ack_missing", int'(gate.exit_ack), 1);
            end

            if (st_q.size() != 0 && st_q[0].due <= cyc) begin
                ms   = st_q.pop_front();
                m_uc = ucap(ms.hr);
                m_uf = (m_uc > ms.up) ? m_uc - ms.up : 0;
                m_gf = ((TOTAL - m_uc) > ms.gp) ? (TOTAL - m_uc) - ms.gp : 0;
                chk("uni_parked", int'(uni_parked), ms.up);
                chk("gen_parked", int'(gen_parked), ms.gp);
                chk("hour", int'(hour), ms.hr);
                chk("minute", int'(minute), ms.mn);
                chk("uni_free", int'(uni_free), m_uf);
                chk("gen_free", int'(gen_free), m_gf);
                chk("uni_avail", int'(uni_avail), int'(m_uf != 0));
                chk("gen_avail", int'(gen_avail), int'(m_gf != 0));
            end
        end
    end

    initial begin
        rst_n         = 0;
        tick_min      = 0;
        time_load     = 0;
        hour_in       = '0;
        gate.ent_req  = 0;
        gate.ent_uni  = 0;
        gate.exit_req = 0;
        gate.exit_uni = 0;
        m_uni = 0; m_gen = 0; m_hour = 0; m_min = 0;

        #3;
        chk("rst_uni_parked", int'(uni_parked), 0);
        chk("rst_gen_parked", int'(gen_parked), 0);
        chk("rst_hour", int'(hour), 0);
        chk("rst_minute", int'(minute), 0);
        chk("rst_uni_free", int'(uni_free), 200);
        chk("rst_gen_free", int'(gen_free), 500);
        chk("rst_ent_ack", int'(gate.ent_ack), 0);
        chk("rst_exit_ack", int'(gate.exit_ack), 0);
        #9;
        rst_n  = 1;
        mon_en = 1;

        // Off-peak admissions at hour 7.
        drive(0, 0, 0, 0, 0, 1, 7);
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("h7_uni_free", int'(uni_free), 199);
        chk("h7_gen_free", int'(gen_free), 499);

        // Peak: fill uni reservation and overflow it back to back.
        drive(0, 0, 0, 0, 0, 1, 8);
        for (int i = 0; i < 501; i++) drive(1, 1, 0, 0, 0, 0, 0);
        settle();
        chk("peak_uni_parked", int'(uni_parked), 500);
        chk("peak_uni_avail", int'(uni_avail), 0);

        // Ramp start shrinks uni capacity below occupancy.
        drive(0, 0, 0, 0, 0, 1, 13);
        drive(1, 1, 0, 0, 0, 0, 0);
        settle();
        chk("ramp_uni_free", int'(uni_free), 0);
        for (int i = 0; i < 60; i++) drive(0, 0, 1, 1, 0, 0, 0);
        settle();
        chk("ramp_uni_parked", int'(uni_parked), 440);
        chk("ramp_uni_free10", int'(uni_free), 10);

        // Exits from general until it is empty, then one more.
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        settle();
        chk("empty_gen_parked", int'(gen_parked), 0);

        // Full uni at hour 9: simultaneous same-class entry and exit.
        drive(0, 0, 0, 0, 0, 1, 9);
        for (int i = 0; i < 60; i++) drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 0, 0, 0);
        settle();
        chk("swap_uni_parked", int'(uni_parked), 500);

        // Day rollover 23:59 -> 00:00, with an entry on the rollover cycle.
        drive(0, 0, 0, 0, 0, 1, 23);
        for (int i = 0; i < 59; i++) drive(0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 0);
        settle();
        chk("roll_hour", int'(hour), 0);
        chk("roll_minute", int'(minute), 0);

        // Randomized traffic with ticks, loads (including out-of-range hours) and mixed requests.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(99) < 70), 1'($urandom), ($urandom_range(99) < 35), 1'($urandom),
                  ($urandom_range(3) == 0), ($urandom_range(49) == 0), int'($urandom_range(31)));
        end
        settle();

        // Asynchronous reset while acknowledges are high.
        drive(1, 1, 1, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        mon_en = 0;
        rst_n  = 0;
        #1;
        chk("arst_uni_parked", int'(uni_parked), 0);
        chk("arst_gen_parked", int'(gen_parked), 0);
        chk("arst_ent_ack", int'(gate.ent_ack), 0);
        chk("arst_exit_ack", int'(gate.exit_ack), 0);
        chk("arst_grant", int'(gate.ent_grant), 0);
        chk("arst_hour", int'(hour), 0);
        gate.ent_req  = 0;
        gate.exit_req = 0;
        ent_q.delete();
        exit_q.delete();
        st_q.delete();
        m_uni = 0; m_gen = 0; m_hour = 0; m_min = 0;
        @(negedge clk);
        #2;
        rst_n  = 1;
        mon_en = 1;

        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0);
        settle();
        repeat (2) @(posedge clk);
        #1;
        chk("ent_q_drained", ent_q.size(), 0);
        chk("exit_q_drained", exit_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
